mem_arbiter: RTL

//  Two-requester round-robin arbiter in front of the 16x8 single-port BSRAM (mem).

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port BSRAM.
// One command per clock; read data is routed back to the issuing port.
module mem_arbiter #(
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          mem_ce,
    output logic          mem_wre,
    output logic          mem_oce,
    output logic [AW-1:0] mem_ad,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    logic              last;
    logic              acc;
    logic              sel;
    logic              cmd_wr;
    logic [AW-1:0]     cmd_ad;
    logic [DW-1:0]     cmd_din;
    logic              iss_v;
    logic              iss_p;
    logic [RD_LAT-1:0] pv;
    logic [RD_LAT-1:0] pp;

    // last = port granted most recently; the other port wins a tie
    always_comb begin
        gnt0 = req0 && (!req1 || last);
        gnt1 = req1 && (!req0 || !last);
    end

    assign acc     = (req0 && gnt0) || (req1 && gnt1);
    assign sel     = gnt1;
    assign cmd_wr  = sel ? wr1 : wr0;
    assign cmd_ad  = sel ? addr1 : addr0;
    assign cmd_din = sel ? wdata1 : wdata0;

    assign mem_ce  = 1'b1;
    assign mem_oce = |pv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last    <= 1'b1;
            mem_wre <= 1'b0;
            mem_ad  <= '0;
            mem_din <= '0;
            iss_v   <= 1'b0;
            iss_p   <= 1'b0;
        end else begin
            mem_wre <= acc && cmd_wr;
            iss_v   <= acc && !cmd_wr;
            iss_p   <= sel;
            if (acc) begin
                last    <= sel;
                mem_ad  <= cmd_ad;
                mem_din <= cmd_din;
            end
        end
    end

    // Tracks reads from the mem_* stage until mem_dout is valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            pp <= '0;
        end else begin
            pv[0] <= iss_v;
            pp[0] <= iss_p;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pp[i] <= pp[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= pv[RD_LAT-1] && !pp[RD_LAT-1];
            rvalid1 <= pv[RD_LAT-1] && pp[RD_LAT-1];
            if (pv[RD_LAT-1] && !pp[RD_LAT-1])
                rdata0 <= mem_dout;
            if (pv[RD_LAT-1] && pp[RD_LAT-1])
                rdata1 <= mem_dout;
        end
    end

endmodule
